// File: rtl/bram_to_axis.sv
// Streams one buffered BRAM line per full-trigger as an AXI4-Stream video line,
// using a credit-limited prefetch FIFO to hide BRAM read latency.
module bram_to_axis #(
  parameter int WD_FRAME_START = 3,
  parameter int NB_FRAME_ALLS  = 720,
  parameter int WD_BRAM_DAT    = 32,
  parameter int WD_BRAM_ADR    = 9,
  parameter int WD_BRAM_WEN    = 1,
  parameter int NB_BRAM_ONC    = 512,
  parameter int NB_BRAM_LAT    = 2,
  parameter int NB_FIFO_DEPTH  = 8,
  parameter int NB_STALL_MAX   = 4096,
  parameter int WD_ERR_INFO    = 4
) (
  input  logic                      i_sys_clk,
  input  logic                      i_sys_resetn,
  input  logic                      i_bram_full_trig,
  input  logic [WD_FRAME_START-1:0] i_frame_start_trig,
  output logic                      o_bram_empty_trig,
  output logic [WD_BRAM_ADR-1:0]    m_bram_rd_addr,
  output logic                      m_bram_rd_clk,
  output logic [WD_BRAM_DAT-1:0]    m_bram_rd_din,
  input  logic [WD_BRAM_DAT-1:0]    m_bram_rd_dout,
  output logic                      m_bram_rd_en,
  output logic                      m_bram_rd_rst,
  output logic [WD_BRAM_WEN-1:0]    m_bram_rd_we,
  output logic [WD_BRAM_DAT-1:0]    m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tuser,
  output logic [WD_ERR_INFO-1:0]    m_err_shk_info2
);

  localparam int PTR_W   = $clog2(NB_FIFO_DEPTH);
  localparam int CNT_W   = $clog2(NB_FIFO_DEPTH) + 1;
  localparam int LINE_W  = (NB_FRAME_ALLS > 1) ? $clog2(NB_FRAME_ALLS) : 1;
  localparam int STALL_W = $clog2(NB_STALL_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic [WD_BRAM_ADR-1:0]   rd_addr;
  logic [WD_BRAM_ADR-1:0]   beat_cnt;
  logic [CNT_W-1:0]         credit;
  logic [NB_BRAM_LAT-1:0]   vpipe;
  logic [WD_BRAM_DAT-1:0]   fifo_mem [NB_FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         fifo_cnt;
  logic                     out_valid;
  logic [WD_BRAM_DAT-1:0]   out_data;
  logic [LINE_W-1:0]        line_cnt;
  logic                     frame_pend;
  logic [STALL_W-1:0]       stall_cnt;
  logic [3:0]               err_q;

  logic issue, pop, push, load_out, mem_rd, mem_wr, bypass;
  logic mem_empty, mem_full, overflow;
  logic last_issue, last_beat, frame_any, stalled, stall_hit;

  assign frame_any  = |i_frame_start_trig;
  assign last_issue = (rd_addr == WD_BRAM_ADR'(NB_BRAM_ONC - 1));
  assign last_beat  = (beat_cnt == WD_BRAM_ADR'(NB_BRAM_ONC - 1));

  // FWFT output stage: refill the output register from storage, or straight
  // from the BRAM when storage is empty, whenever it is empty or being consumed.
  assign pop       = out_valid && m_axis_tready;
  assign push      = vpipe[NB_BRAM_LAT-1];
  assign mem_empty = (fifo_cnt == '0);
  assign mem_full  = (fifo_cnt == CNT_W'(NB_FIFO_DEPTH));
  assign load_out  = !out_valid || pop;
  assign mem_rd    = load_out && !mem_empty;
  assign bypass    = load_out && mem_empty && push;
  assign mem_wr    = push && !bypass;
  assign overflow  = mem_wr && mem_full && !mem_rd;

  assign stalled   = out_valid && !m_axis_tready;
  assign stall_hit = stalled && (stall_cnt == STALL_W'(NB_STALL_MAX - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt         = state;
    issue             = 1'b0;
    m_bram_rd_rst     = 1'b0;
    o_bram_empty_trig = 1'b0;
    unique case (state)
      S_IDLE: begin
        m_bram_rd_rst = 1'b1;
        if (i_bram_full_trig) state_nxt = S_READ;
      end
      S_READ: begin
        issue = (credit < CNT_W'(NB_FIFO_DEPTH));
        if (issue && last_issue) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && last_beat) state_nxt = S_DONE;
      end
      S_DONE: begin
        o_bram_empty_trig = 1'b1;
        state_nxt         = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) state <= S_IDLE;
    else               state <= state_nxt;
  end

  // Credits cover reads in flight plus everything buffered, so storage never overflows.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      rd_addr  <= '0;
      beat_cnt <= '0;
      credit   <= '0;
      vpipe    <= '0;
    end else begin
      if (issue) rd_addr <= last_issue ? '0 : rd_addr + WD_BRAM_ADR'(1);
      if (pop)   beat_cnt <= last_beat ? '0 : beat_cnt + WD_BRAM_ADR'(1);
      unique case ({issue, pop})
        2'b10:   credit <= credit + CNT_W'(1);
        2'b01:   credit <= credit - CNT_W'(1);
        default: credit <= credit;
      endcase
      vpipe[0] <= issue;
      for (int i = 1; i < NB_BRAM_LAT; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  // NOTE: storage array carries no reset; only pointers and counts define its contents.
  always_ff @(posedge i_sys_clk) begin
    if (mem_wr) fifo_mem[wr_ptr] <= m_bram_rd_dout;
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (mem_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({mem_wr, mem_rd})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (load_out) begin
        if (mem_rd) begin
          out_data  <= fifo_mem[rd_ptr];
          out_valid <= 1'b1;
        end else if (push) begin
          out_data  <= m_bram_rd_dout;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  // A mid-line frame start is deferred to the line boundary so the current tuser is untouched.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      line_cnt   <= '0;
      frame_pend <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (frame_any) line_cnt <= '0;
        S_DONE: begin
          frame_pend <= 1'b0;
          if (frame_any || frame_pend || line_cnt == LINE_W'(NB_FRAME_ALLS - 1))
            line_cnt <= '0;
          else
            line_cnt <= line_cnt + LINE_W'(1);
        end
        default: if (frame_any) frame_pend <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      stall_cnt <= '0;
      err_q     <= '0;
    end else begin
      if (!stalled)                                    stall_cnt <= '0;
      else if (stall_cnt != STALL_W'(NB_STALL_MAX))    stall_cnt <= stall_cnt + STALL_W'(1);
      err_q <= {overflow,
                stall_hit,
                frame_any && (state != S_IDLE),
                i_bram_full_trig && (state != S_IDLE)};
    end
  end

  assign m_bram_rd_clk   = i_sys_clk;
  assign m_bram_rd_din   = '0;
  assign m_bram_rd_we    = '0;
  assign m_bram_rd_en    = issue;
  assign m_bram_rd_addr  = rd_addr;

  assign m_axis_tdata    = out_data;
  assign m_axis_tvalid   = out_valid;
  assign m_axis_tlast    = out_valid && last_beat;
  assign m_axis_tuser    = out_valid && (beat_cnt == '0) && (line_cnt == '0);
  assign m_err_shk_info2 = WD_ERR_INFO'(err_q);

endmodule

// File: doc/bram_to_axis.md
# bram_to_axis

Downstream stage of the DDR-to-BRAM loader. On each line-full trigger it reads one buffered line, NB_BRAM_ONC words, out of the shared line BRAM. It emits the line as an AXI4-Stream video line with tlast at end-of-line and tuser at start-of-frame, then pulses a line-empty trigger back to the loader and to software. A small prefetch FIFO hides BRAM read latency, so the block sustains one beat per cycle under full tready.

## Interface
- WD_FRAME_START, 3: width of frame start trigger vector
- NB_FRAME_ALLS, 720: lines per frame
- WD_BRAM_DAT, 32: BRAM data width, equal to tdata width
- WD_BRAM_ADR, 9: BRAM address width
- WD_BRAM_WEN, 1: BRAM write-enable width
- NB_BRAM_ONC, 512: words per line; must be ≤ 2^WD_BRAM_ADR
- NB_BRAM_LAT, 2: BRAM read latency in cycles, 1..4
- NB_FIFO_DEPTH, 8: prefetch FIFO depth; must be ≥ NB_BRAM_LAT+2, power of 2
- NB_STALL_MAX, 4096: tready-low cycle count that flags a stall error
- WD_ERR_INFO, 4: error info width
- i_sys_clk  in  1  system clock
- i_sys_resetn  in  1  reset, asynchronous, active-low
- i_bram_full_trig  in  1  one-cycle pulse: BRAM line written, ready to read
- i_frame_start_trig  in  WD_FRAME_START  frame start; any bit set restarts line count
- o_bram_empty_trig  out  1  one-cycle pulse: line fully streamed
- m_bram_rd_addr  out  WD_BRAM_ADR  BRAM read address
- m_bram_rd_clk  out  1  BRAM clock, driven by i_sys_clk
- m_bram_rd_din  out  WD_BRAM_DAT  BRAM write data, tied 0
- m_bram_rd_dout  in  WD_BRAM_DAT  BRAM read data
- m_bram_rd_en  out  1  BRAM enable
- m_bram_rd_rst  out  1  BRAM reset, active high
- m_bram_rd_we  out  WD_BRAM_WEN  BRAM write enable, tied 0
- m_axis_tdata  out  WD_BRAM_DAT  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  last beat of line
- m_axis_tuser  out  1  first beat of frame
- m_err_shk_info2  out  WD_ERR_INFO  error pulses; bit map under Operation

## Operation

**Reset values** (async on i_sys_resetn=0, applied immediately, including mid-line):
- all outputs 0, except m_bram_rd_rst=1
- state IDLE; FIFO, credit counter and line counter cleared

**States:**
- IDLE: rd_rst=1, rd_en=0.
  - i_bram_full_trig=1 → READ.
- READ: rd_rst=0, rd_en=1.
  - Issue a read (addr++) only when outstanding reads + FIFO occupancy < NB_FIFO_DEPTH.
  - Issued reads enter a NB_BRAM_LAT-deep valid pipe; returning data is pushed into the FIFO.
  - After address NB_BRAM_ONC-1 is issued → DRAIN.
- DRAIN: rd_en=0.
  - Wait for the handshake (tvalid&tready) of beat NB_BRAM_ONC-1, then → DONE.
- DONE: one cycle; o_bram_empty_trig=1; line counter advances → IDLE.

**Stream:**
- FIFO is first-word fall-through with registered output.
- tlast=1 only on beat NB_BRAM_ONC-1.
- tuser=1 only on beat 0 when line counter = 0.
- tdata/tvalid/tlast/tuser hold stable while tvalid=1 and tready=0.

**Line counter:**
- 0..NB_FRAME_ALLS-1; wraps to 0 after the last line.
- Any i_frame_start_trig bit set clears it to 0.
  - In IDLE: takes effect for the next line.
  - Mid-line: the current line's tuser is unchanged, the clear applies from the next line, and it also flags error bit 1.
  - If the clear coincides with DONE, the clear wins (counter = 0).

**Error bits** (registered one-cycle pulses, 0 when idle):
- [0] i_bram_full_trig while state ≠ IDLE; the trigger is ignored.
- [1] i_frame_start_trig while state ≠ IDLE.
- [2] tvalid=1 and tready=0 for exactly NB_STALL_MAX consecutive cycles; fires once per stall.
- [3] FIFO push while full; cannot occur under the credit rule and exists as a design assertion.

**Boundary cases:**
- A full trigger in the DONE cycle is ignored and flags error bit [0]; the upstream stage must wait for o_bram_empty_trig.
- Width rule: addresses are WD_BRAM_ADR wide; the credit counter is log2(NB_FIFO_DEPTH)+1 bits.

## Timing
- Trigger sampled at edge T: READ from T+1; rd_en=1 and addr=0 visible in T+1.
- Data returns at T+1+NB_BRAM_LAT and is pushed into the FIFO.
- First tvalid at T+2+NB_BRAM_LAT (T+4 at default).
- With tready held 1: one beat per cycle and no bubbles; tlast at T+3+NB_BRAM_LAT+NB_BRAM_ONC-2 (T+515 at default).
- o_bram_empty_trig one cycle after the tlast handshake; IDLE the cycle after that.
- A new full trigger is accepted in the first IDLE cycle.
- tready→tvalid path is registered, with no combinational path through the block.

## Test plan
- Single line, tready=1: BRAM preloaded with data = addr. Full trig at T → tvalid from T+4; beats 0..511 carry data 0..511 in order; tlast only on beat 511 at T+515; tuser=1 on beat 0; empty trig at T+516.
- Backpressure: tready random at 30% high → still 512 beats, in order, with no loss or duplication; FIFO never overflows (err[3] stays 0); rd_en deasserts while credits are exhausted.
- Frame wrap: NB_FRAME_ALLS=3, 7 lines → tuser on lines 0, 3, 6 only. A frame start between lines 1 and 2 → tuser on line 2.
- Trigger while busy: second full trig at T+100 → err[0] pulse at T+101; output unchanged at 512 beats and one empty trig.
- Stall: NB_STALL_MAX=16, tready=0 for 40 cycles mid-line → exactly one err[2] pulse, 16 cycles into the stall.
- Async reset at beat 200: outputs return to reset values with no clock edge; the next full trig restarts cleanly from addr 0 with tuser=1.
